// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed 7-segment driver with double-buffered load.
// Scans NUM_DIGITS digits, one CLK_DIV-cycle slot each. Supports per-digit decimal points,
// a blank mask, leading-zero suppression and PWM brightness. A ghost guard keeps prescaler
// slot 0 dark. New data is swapped in only at frame boundaries.
// Optional feature: define SEG7_BLINK_EN to add the blink_mask port and a frame-based blink phase.
module seg7_scan_display #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_suppress,
  input  logic [PWM_BITS-1:0]     bright,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    ready,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    seg_dp
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PreW = $clog2(CLK_DIV);
  // Wide enough for (bright+1)*(CLK_DIV-1) without truncation.
  localparam int unsigned ThrW = PreW + PWM_BITS + 1;

  localparam logic [PreW-1:0]       PreMax   = PreW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0]       IdxMax   = IdxW'(NUM_DIGITS - 1);
  localparam logic                  Inv      = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AnodeOff = {NUM_DIGITS{Inv}};
  localparam logic [6:0]            SegOff   = {7{Inv}};

  // Reject illegal configurations at elaboration.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 16 || CLK_DIV < 8 || PWM_BITS < 1 || BLINK_FRAMES < 1)
  begin : g_bad_params
    $error("seg7_scan_display: illegal parameter value");
  end

  // Active-high gfedcba hex font.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [PreW-1:0]         pre_q;
  logic [IdxW-1:0]         idx_q;
  logic                    pre_wrap;
  logic                    frame_end;
  logic                    pending_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   sh_blank_q, act_blank_q;
  logic                    frame_tick_q;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, cur_lz, cur_blink;
  logic [ThrW-1:0]         thr;
  logic                    pwm_on, lit;
  logic [NUM_DIGITS-1:0]   anode_d, anode_q;
  logic [6:0]              seg_d, seg_q;
  logic                    seg_dp_d, seg_dp_q;

  assign pre_wrap  = (pre_q == PreMax);
  assign frame_end = pre_wrap && (idx_q == IdxMax);

  // Slot prescaler and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_wrap) begin
      pre_q <= '0;
      idx_q <= (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Shadow capture on accept; shadow-to-active swap only at the frame boundary.
  // Swap uses the pre-accept pending, so a same-cycle accept waits one more frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= 1'b0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_end;
      if (frame_end && pending_q) begin
        act_data_q  <= sh_data_q;
        act_dp_q    <= sh_dp_q;
        act_blank_q <= sh_blank_q;
        pending_q   <= 1'b0;
      end
      if (load && !pending_q) begin
        sh_data_q  <= data;
        sh_dp_q    <= dp;
        sh_blank_q <= blank;
        pending_q  <= 1'b1;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] sh_blink_q, act_blink_q;
  logic [BlinkW-1:0]     blink_cnt_q;
  logic                  blink_phase_q;

  // Blink mask buffering and frame counter toggling the blink phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_blink_q    <= '0;
      act_blink_q   <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      if (frame_end && pending_q) act_blink_q <= sh_blink_q;
      if (load && !pending_q)     sh_blink_q  <= blink_mask;
      if (frame_end) begin
        if (blink_cnt_q == BlinkMax) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end
`endif

  // Select the current digit's attributes and its leading-zero status.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_lz     = 1'b0;
    cur_blink  = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (act_data_q[4*i +: 4] == 4'h0);
      if (idx_q == IdxW'(i)) begin
        cur_nib   = act_data_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = act_blank_q[i];
        cur_lz    = upper_zero && (i != 0);
`ifdef SEG7_BLINK_EN
        cur_blink = blink_phase_q && act_blink_q[i];
`endif
      end
    end
  end

  // PWM window: slot 0 stays dark, lit through ((bright+1)*(CLK_DIV-1)) >> PWM_BITS.
  assign thr    = ((ThrW'(bright) + ThrW'(1)) * ThrW'(CLK_DIV - 1)) >> PWM_BITS;
  assign pwm_on = (pre_q != '0) && (ThrW'(pre_q) <= thr);
  assign lit    = pwm_on && !cur_blank && !(lz_suppress && cur_lz) && !cur_blink;

  // Next-state output drive; a dark digit leaves every output inactive.
  always_comb begin
    anode_d  = AnodeOff;
    seg_d    = SegOff;
    seg_dp_d = Inv;
    if (lit) begin
      anode_d  = AnodeOff ^ (NUM_DIGITS'(1) << idx_q);
      seg_d    = hex_font(cur_nib) ^ SegOff;
      seg_dp_d = cur_dp ^ Inv;
    end
  end

  // Registered outputs, one cycle behind prescaler/index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anode_q  <= AnodeOff;
      seg_q    <= SegOff;
      seg_dp_q <= Inv;
    end else begin
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
    end
  end

  assign ready      = !pending_q;
  assign frame_tick = frame_tick_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display (4 digits, 8-cycle slots, 2-bit brightness, active-low).
// A time-based reference model predicts every registered output from cycle count arithmetic.
module tb_seg7_scan_display;

  localparam int ND    = 4;
  localparam int CD    = 8;
  localparam int PB    = 2;
  localparam int FRAME = ND * CD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        lz_suppress = 1'b0;
  logic [1:0]  bright = 2'd3;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic        ready, frame_tick, seg_dp;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_display #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (CD),
    .PWM_BITS    (PB),
    .ACTIVE_LOW  (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .lz_suppress(lz_suppress),
    .bright     (bright),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .ready      (ready),
    .frame_tick (frame_tick),
    .anode      (anode),
    .seg        (seg),
    .seg_dp     (seg_dp)
  );

  always #5 clk = ~clk;

  // Active-low gfedcba font, digits 0..F.
  logic [6:0] font_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state: t = clock edges since reset release.
  int          t;
  logic        m_pend;
  logic [15:0] m_sh_d, m_act_d;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_bl, m_act_bl;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft;

  wire [13:0] got     = {anode, seg, seg_dp, ready, frame_tick};
  wire [13:0] exp_vec = {e_an, e_seg, e_dp, !m_pend, e_ft};

  // Display rule for cycle tt: slot position, digit, brightness window, blank, leading zeros.
  function automatic logic [11:0] model_out(int tt, logic [15:0] d, logic [3:0] dpv,
                                            logic [3:0] bl, logic lz, logic [1:0] br);
    int   p;
    int   k;
    int   thr;
    logic lit;
    logic [3:0] nib;
    p   = tt % CD;
    k   = (tt / CD) % ND;
    thr = ((int'(br) + 1) * (CD - 1)) >> PB;
    nib = 4'(d >> (4 * k));
    lit = (p >= 1) && (p <= thr) && !bl[k] && !(lz && k > 0 && (d >> (4 * k)) == 16'h0);
    if (lit) return {~(4'b0001 << k), font_lo[nib], ~dpv[k]};
    return {4'hF, 7'h7F, 1'b1};
  endfunction

  // Model advance per clock: outputs, frame tick, accept and frame-boundary swap.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t        <= 0;
      m_pend   <= 1'b0;
      m_sh_d   <= '0;
      m_sh_dp  <= '0;
      m_sh_bl  <= '0;
      m_act_d  <= '0;
      m_act_dp <= '0;
      m_act_bl <= '0;
      e_an     <= 4'hF;
      e_seg    <= 7'h7F;
      e_dp     <= 1'b1;
      e_ft     <= 1'b0;
    end else begin
      {e_an, e_seg, e_dp} <= model_out(t, m_act_d, m_act_dp, m_act_bl, lz_suppress, bright);
      e_ft <= (t % FRAME) == FRAME - 1;
      if ((t % FRAME) == FRAME - 1 && m_pend) begin
        m_act_d  <= m_sh_d;
        m_act_dp <= m_sh_dp;
        m_act_bl <= m_sh_bl;
        m_pend   <= 1'b0;
      end
      if (load && !m_pend) begin
        m_sh_d  <= data;
        m_sh_dp <= dp;
        m_sh_bl <= blank;
        m_pend  <= 1'b1;
      end
      t <= t + 1;
    end
  end

  // Frame capture results.
  logic [6:0] cap_seg [4];
  int         cap_cnt [4];
  logic [7:0] cap_pos [4];
  int         cap_bad;

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    load = 1'b1;
    data = d;
    dp   = p;
    blank = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Observes one frame of outputs: per-digit seg code, lit count and lit slot positions.
  task automatic capture_frame;
    cap_bad = 0;
    for (int i = 0; i < ND; i++) begin
      cap_cnt[i] = 0;
      cap_seg[i] = 7'h7F;
      cap_pos[i] = '0;
    end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (got !== exp_vec) cap_bad++;
      if (anode !== 4'hF) begin
        int d;
        int lows;
        d = 0;
        lows = 0;
        for (int k = 0; k < ND; k++) if (anode[k] === 1'b0) begin d = k; lows++; end
        if (lows != 1) cap_bad++;
        else begin
          cap_cnt[d]++;
          cap_seg[d] = seg;
          cap_pos[d][(t - 1) % CD] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_ready(output bit ok, output int bad);
    ok = 1'b0;
    bad = 0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      if (got !== exp_vec) bad++;
      if (ready === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (anode !== 4'hF) begin n_errors++; $display("FAIL reset_anode got=%h exp=f", anode); end
    n_checks++; if (seg !== 7'h7F) begin n_errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
    n_checks++; if (seg_dp !== 1'b1) begin n_errors++; $display("FAIL reset_dp got=%b exp=1", seg_dp); end
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_checks++; if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (anode !== 4'hF) begin n_errors++; $display("FAIL reset_presc0 got=%h exp=f", anode); end
    @(negedge clk);
    n_checks++;
    if (anode !== 4'b1110 || seg !== 7'h40) begin
      n_errors++; $display("FAIL reset_first_digit got=%h/%h exp=e/40", anode, seg);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      n_checks++;
      if (got !== exp_vec) begin n_errors++; $display("FAIL reset_model t=%0d got=%h exp=%h", t, got, exp_vec); end
    end
  endtask

  task automatic test_reset_midframe;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (anode === 4'b1011) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL midframe_find got=none exp=digit2"); end
    do_load(16'h8888, 4'hF, 4'h0);
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL midframe_pending got=%b exp=0", ready); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (anode !== 4'hF || seg !== 7'h7F || seg_dp !== 1'b1 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midframe_reset got=%h/%h/%b/%b exp=f/7f/1/1", anode, seg, seg_dp, ready);
    end
    @(negedge clk);
    reset = 1'b0;
    capture_frame;
    n_checks++; if (cap_bad != 0) begin n_errors++; $display("FAIL midframe_model got=%0d exp=0", cap_bad); end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (cap_seg[d] !== 7'h40 || cap_cnt[d] != 7) begin
        n_errors++; $display("FAIL midframe_digit%0d got=%h/%0d exp=40/7", d, cap_seg[d], cap_cnt[d]);
      end
    end
  endtask

  task automatic test_load;
    bit ok;
    int bad;
    logic [6:0] exp_s [4];
    exp_s = '{7'h19, 7'h30, 7'h24, 7'h79};
    bright = 2'd3;
    do_load(16'h1234, 4'h0, 4'h0);
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL load_ready_low got=%b exp=0", ready); end
    wait_ready(ok, bad);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL load_ready_rise got=timeout exp=ready"); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL load_wait_model got=%0d exp=0", bad); end
    capture_frame;
    n_checks++; if (cap_bad != 0) begin n_errors++; $display("FAIL load_model got=%0d exp=0", cap_bad); end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (cap_seg[d] !== exp_s[d] || cap_cnt[d] != 7) begin
        n_errors++;
        $display("FAIL load_digit%0d got=%h/%0d exp=%h/7", d, cap_seg[d], cap_cnt[d], exp_s[d]);
      end
    end
  endtask

  task automatic test_busy_load;
    bit ok;
    int bad;
    logic [6:0] exp_s [4];
    exp_s = '{7'h79, 7'h30, 7'h40, 7'h00};
    do_load(16'h8031, 4'h0, 4'h0);
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL busy_first got=%b exp=0", ready); end
    do_load(16'hFFFF, 4'hF, 4'h0);
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL busy_second got=%b exp=0", ready); end
    wait_ready(ok, bad);
    n_checks++; if (!ok || bad != 0) begin n_errors++; $display("FAIL busy_wait got=%b/%0d exp=1/0", ok, bad); end
    capture_frame;
    n_checks++; if (cap_bad != 0) begin n_errors++; $display("FAIL busy_model got=%0d exp=0", cap_bad); end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (cap_seg[d] !== exp_s[d]) begin
        n_errors++; $display("FAIL busy_digit%0d got=%h exp=%h", d, cap_seg[d], exp_s[d]);
      end
    end
  endtask

  task automatic test_lz;
    bit ok;
    int bad;
    lz_suppress = 1'b1;
    do_load(16'h0042, 4'h0, 4'h0);
    wait_ready(ok, bad);
    n_checks++; if (!ok || bad != 0) begin n_errors++; $display("FAIL lz_wait got=%b/%0d exp=1/0", ok, bad); end
    capture_frame;
    n_checks++; if (cap_bad != 0) begin n_errors++; $display("FAIL lz_model got=%0d exp=0", cap_bad); end
    n_checks++;
    if (cap_cnt[3] != 0 || cap_cnt[2] != 0) begin
      n_errors++; $display("FAIL lz_dark32 got=%0d/%0d exp=0/0", cap_cnt[3], cap_cnt[2]);
    end
    n_checks++;
    if (cap_seg[1] !== 7'h19 || cap_seg[0] !== 7'h24) begin
      n_errors++; $display("FAIL lz_lit10 got=%h/%h exp=19/24", cap_seg[1], cap_seg[0]);
    end
    do_load(16'h0000, 4'h0, 4'h0);
    wait_ready(ok, bad);
    n_checks++; if (!ok || bad != 0) begin n_errors++; $display("FAIL lz0_wait got=%b/%0d exp=1/0", ok, bad); end
    capture_frame;
    n_checks++; if (cap_bad != 0) begin n_errors++; $display("FAIL lz0_model got=%0d exp=0", cap_bad); end
    n_checks++;
    if (cap_cnt[1] + cap_cnt[2] + cap_cnt[3] != 0) begin
      n_errors++; $display("FAIL lz0_upper got=%0d exp=0", cap_cnt[1] + cap_cnt[2] + cap_cnt[3]);
    end
    n_checks++;
    if (cap_seg[0] !== 7'h40 || cap_cnt[0] != 7) begin
      n_errors++; $display("FAIL lz0_digit0 got=%h/%0d exp=40/7", cap_seg[0], cap_cnt[0]);
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_bright;
    for (int br = 0; br < 4; br++) begin
      int thr;
      logic [7:0] ep;
      bright = 2'(br);
      @(negedge clk);
      thr = ((br + 1) * (CD - 1)) >> PB;
      ep = '0;
      for (int p = 1; p <= thr; p++) ep[p] = 1'b1;
      capture_frame;
      n_checks++;
      if (cap_bad != 0) begin n_errors++; $display("FAIL bright%0d_model got=%0d exp=0", br, cap_bad); end
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (cap_pos[d] !== ep) begin
          n_errors++; $display("FAIL bright%0d_digit%0d got=%b exp=%b", br, d, cap_pos[d], ep);
        end
      end
    end
    bright = 2'd3;
  endtask

  task automatic test_boundary_accept;
    bit found;
    found = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      if ((t % FRAME) == FRAME - 1 && ready === 1'b1) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL ba_find got=none exp=boundary"); end
    do_load(16'h4321, 4'h0, 4'h0);
    n_checks++; if (frame_tick !== 1'b1) begin n_errors++; $display("FAIL ba_tick got=%b exp=1", frame_tick); end
    n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL ba_ready0 got=%b exp=0", ready); end
    for (int c = 1; c < FRAME; c++) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b0 || got !== exp_vec) begin
        n_errors++; $display("FAIL ba_hold c=%0d got=%h exp=%h", c, got, exp_vec);
      end
    end
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL ba_ready1 got=%b exp=1", ready); end
    capture_frame;
    n_checks++;
    if (cap_bad != 0 || cap_seg[0] !== 7'h79 || cap_seg[3] !== 7'h19) begin
      n_errors++; $display("FAIL ba_show got=%0d/%h/%h exp=0/79/19", cap_bad, cap_seg[0], cap_seg[3]);
    end
  endtask

  task automatic test_back_to_back;
    load = 1'b1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      data = 16'($urandom);
      dp   = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if (got !== exp_vec) begin n_errors++; $display("FAIL b2b t=%0d got=%h exp=%h", t, got, exp_vec); end
    end
    load = 1'b0;
  endtask

  task automatic test_random;
    for (int c = 0; c < 20 * FRAME; c++) begin
      @(negedge clk);
      n_checks++;
      if (got !== exp_vec) begin n_errors++; $display("FAIL rand t=%0d got=%h exp=%h", t, got, exp_vec); end
      load        = ($urandom_range(0, 3) == 0);
      data        = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp          = 4'($urandom);
      blank       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_suppress = 1'($urandom);
      bright      = 2'($urandom);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset;
    test_reset_midframe;
    test_load;
    test_busy_load;
    test_lz;
    test_bright;
    test_boundary_accept;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
